// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled serial input, 8 data bits,
// optional even parity, one stop bit, RX FIFO write interface.
module uart_receiver (
    input  logic       pclk,
    input  logic       prst_n,
    input  logic       brg_rx_sample,
    input  logic       apb_d9,
    input  logic       apb_af,
    input  logic       apb_rx_en,
    input  logic       rx_rxff_full,
    input  logic       uart_rx,
    output logic       rx_rxff_wr,
    output logic [7:0] rx_data,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       uart_rts,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t     r_state;
    state_t     w_state_n;
    logic [3:0] r_tcnt;
    logic [3:0] w_tcnt_n;
    logic [2:0] r_bidx;
    logic [2:0] w_bidx_n;
    logic [7:0] r_shreg;
    logic [7:0] w_shreg_n;
    logic       r_d9;
    logic       w_d9_n;
    logic       r_perr;
    logic       w_perr_n;
    logic       r_ferr;
    logic       w_ferr_n;
    logic       r_done;
    logic       w_done_n;
    logic       r_rx_m;
    logic       r_rx_s;

    // Two-flop synchronizer for the asynchronous serial line
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_rx_m <= uart_rx;
            r_rx_s <= r_rx_m;
        end
    end

    // Receiver state, counters and shift register
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            r_state <= S_IDLE;
            r_tcnt  <= 4'd0;
            r_bidx  <= 3'd0;
            r_shreg <= 8'h00;
            r_d9    <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_tcnt  <= w_tcnt_n;
            r_bidx  <= w_bidx_n;
            r_shreg <= w_shreg_n;
            r_d9    <= w_d9_n;
            r_perr  <= w_perr_n;
            r_ferr  <= w_ferr_n;
            r_done  <= w_done_n;
        end
    end

    // Next-state logic; everything advances on sample ticks only
    always_comb begin
        w_state_n = r_state;
        w_tcnt_n  = r_tcnt;
        w_bidx_n  = r_bidx;
        w_shreg_n = r_shreg;
        w_d9_n    = r_d9;
        w_perr_n  = r_perr;
        w_ferr_n  = r_ferr;
        w_done_n  = 1'b0;
        if (!apb_rx_en) begin
            w_state_n = S_IDLE;
            w_tcnt_n  = 4'd0;
            w_bidx_n  = 3'd0;
            w_perr_n  = 1'b0;
        end else if (brg_rx_sample) begin
            unique case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        w_state_n = S_START;
                        w_tcnt_n  = 4'd0;
                    end
                end
                S_START: begin
                    w_tcnt_n = r_tcnt + 4'd1;
                    if (r_tcnt == 4'd7) begin
                        w_tcnt_n = 4'd0;
                        if (!r_rx_s) begin
                            w_state_n = S_DATA;
                            w_bidx_n  = 3'd0;
                            w_d9_n    = apb_d9;
                            w_perr_n  = 1'b0;
                        end else begin
                            w_state_n = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    w_tcnt_n = r_tcnt + 4'd1;
                    if (r_tcnt == 4'd15) begin
                        w_shreg_n = {r_rx_s, r_shreg[7:1]};
                        w_bidx_n  = r_bidx + 3'd1;
                        if (r_bidx == 3'd7) begin
                            w_state_n = r_d9 ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    w_tcnt_n = r_tcnt + 4'd1;
                    if (r_tcnt == 4'd15) begin
                        w_perr_n  = r_rx_s ^ (^r_shreg);
                        w_state_n = S_STOP;
                    end
                end
                S_STOP: begin
                    w_tcnt_n = r_tcnt + 4'd1;
                    if (r_tcnt == 4'd15) begin
                        w_ferr_n  = ~r_rx_s;
                        w_done_n  = 1'b1;
                        w_state_n = S_IDLE;
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    // Deliver the completed byte one cycle after the stop sample
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            rx_rxff_wr    <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_data       <= 8'h00;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_rxff_wr <= 1'b0;
            rx_overrun <= 1'b0;
            if (r_done && apb_rx_en) begin
                if (!rx_rxff_full) begin
                    rx_rxff_wr    <= 1'b1;
                    rx_data       <= r_shreg;
                    rx_parity_err <= r_perr & r_d9;
                    rx_frame_err  <= r_ferr;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end
        end
    end

    assign uart_rts = apb_af & rx_rxff_full;
    assign rx_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver.
// Ticks every 4 pclk, so one bit time is 64 pclk.
module tb_uart_receiver;

    logic       pclk;
    logic       prst_n;
    logic       brg_rx_sample;
    logic       apb_d9;
    logic       apb_af;
    logic       apb_rx_en;
    logic       rx_rxff_full;
    logic       uart_rx;
    logic       rx_rxff_wr;
    logic [7:0] rx_data;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       uart_rts;
    logic       rx_busy;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int ovr_cnt  = 0;
    int wr0;
    int ovr0;

    uart_receiver dut (
        .pclk          (pclk),
        .prst_n        (prst_n),
        .brg_rx_sample (brg_rx_sample),
        .apb_d9        (apb_d9),
        .apb_af        (apb_af),
        .apb_rx_en     (apb_rx_en),
        .rx_rxff_full  (rx_rxff_full),
        .uart_rx       (uart_rx),
        .rx_rxff_wr    (rx_rxff_wr),
        .rx_data       (rx_data),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun),
        .uart_rts      (uart_rts),
        .rx_busy       (rx_busy)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Baud tick: one pclk high out of every four
    initial begin
        brg_rx_sample = 1'b0;
        forever begin
            repeat (3) @(posedge pclk);
            #1 brg_rx_sample = 1'b1;
            @(posedge pclk);
            #1 brg_rx_sample = 1'b0;
        end
    end

    // Count strobes away from the active edge
    always @(negedge pclk) begin
        if (rx_rxff_wr) wr_cnt <= wr_cnt + 1;
        if (rx_overrun) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        uart_rx = b;
        repeat (64) @(posedge pclk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_en,
                              input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par_en) send_bit(par);
        send_bit(stop);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic send_partial(input logic [7:0] d, input int n);
        send_bit(1'b0);
        for (int i = 0; i < n; i++) send_bit(d[i]);
    endtask

    initial begin
        prst_n       = 1'b0;
        apb_d9       = 1'b0;
        apb_af       = 1'b0;
        apb_rx_en    = 1'b1;
        rx_rxff_full = 1'b0;
        uart_rx      = 1'b1;
        repeat (4) @(posedge pclk);
        #1;
        chk("rst_data", rx_data, 8'h00);
        chk("rst_perr", rx_parity_err, 1'b0);
        chk("rst_ferr", rx_frame_err, 1'b0);
        chk("rst_wr", rx_rxff_wr, 1'b0);
        chk("rst_ovr", rx_overrun, 1'b0);
        chk("rst_busy", rx_busy, 1'b0);
        chk("rst_rts", uart_rts, 1'b0);
        prst_n = 1'b1;
        repeat (20) @(posedge pclk);
        #1;

        // Plain 8N1 byte
        wr0 = wr_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        chk("a5_wr", wr_cnt - wr0, 1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_perr", rx_parity_err, 1'b0);
        chk("a5_ferr", rx_frame_err, 1'b0);

        // Even parity: correct, then wrong
        apb_d9 = 1'b1;
        wr0 = wr_cnt;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        chk("3c_wr", wr_cnt - wr0, 1);
        chk("3c_data", rx_data, 8'h3C);
        chk("3c_perr", rx_parity_err, 1'b0);
        wr0 = wr_cnt;
        send_frame(8'h3D, 1'b1, 1'b0, 1'b1);
        chk("3d_wr", wr_cnt - wr0, 1);
        chk("3d_data", rx_data, 8'h3D);
        chk("3d_perr", rx_parity_err, 1'b1);
        chk("3d_ferr", rx_frame_err, 1'b0);

        // Framing error
        apb_d9 = 1'b0;
        wr0 = wr_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        chk("55_wr", wr_cnt - wr0, 1);
        chk("55_data", rx_data, 8'h55);
        chk("55_ferr", rx_frame_err, 1'b1);
        chk("55_perr", rx_parity_err, 1'b0);

        // Five-tick glitch on idle line is a false start
        wr0 = wr_cnt;
        uart_rx = 1'b0;
        repeat (12) @(posedge pclk);
        #1;
        chk("glitch_busy_hi", rx_busy, 1'b1);
        repeat (8) @(posedge pclk);
        #1 uart_rx = 1'b1;
        repeat (200) @(posedge pclk);
        #1;
        chk("glitch_wr", wr_cnt - wr0, 0);
        chk("glitch_busy", rx_busy, 1'b0);

        // FIFO full: overrun and RTS
        rx_rxff_full = 1'b1;
        apb_af       = 1'b1;
        #1;
        chk("rts_on", uart_rts, 1'b1);
        wr0  = wr_cnt;
        ovr0 = ovr_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        chk("ovr_wr", wr_cnt - wr0, 0);
        chk("ovr_pulse", ovr_cnt - ovr0, 1);
        chk("ovr_data", rx_data, 8'h55);
        apb_af = 1'b0;
        #1;
        chk("rts_off", uart_rts, 1'b0);
        rx_rxff_full = 1'b0;

        // Disable mid-frame during data bit 4
        wr0 = wr_cnt;
        send_partial(8'h00, 4);
        uart_rx = 1'b0;
        repeat (32) @(posedge pclk);
        #1 apb_rx_en = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        chk("abort_busy", rx_busy, 1'b0);
        uart_rx = 1'b1;
        repeat (128) @(posedge pclk);
        #1 apb_rx_en = 1'b1;
        repeat (128) @(posedge pclk);
        #1;
        chk("abort_wr", wr_cnt - wr0, 0);

        // Reset mid-frame
        wr0 = wr_cnt;
        send_partial(8'h00, 3);
        prst_n = 1'b0;
        #1;
        chk("rstmid_busy", rx_busy, 1'b0);
        chk("rstmid_data", rx_data, 8'h00);
        uart_rx = 1'b1;
        repeat (5) @(posedge pclk);
        #1 prst_n = 1'b1;
        repeat (128) @(posedge pclk);
        #1;
        chk("rstmid_wr", wr_cnt - wr0, 0);
        chk("rstmid_idle", rx_busy, 1'b0);

        // Recovery frame
        wr0 = wr_cnt;
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        chk("0f_wr", wr_cnt - wr0, 1);
        chk("0f_data", rx_data, 8'h0F);
        chk("0f_ferr", rx_frame_err, 1'b0);
        chk("0f_perr", rx_parity_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The module SHALL have a single clock and an asynchronous, active-low reset: one clock; reset is asynchronous and active-low.
REQ-002 The ports SHALL be as follows:
- pclk  in  1  system clock; all state changes on its rising edge.
- prst_n  in  1  asynchronous active-low reset.
- brg_rx_sample  in  1  one-pclk pulse at 16x the baud rate, from the baud rate generator.
- apb_d9  in  1  1 = frame carries an even-parity bit after the data.
- apb_af  in  1  1 = auto flow control enabled.
- apb_rx_en  in  1  receiver enable.
- rx_rxff_full  in  1  RX FIFO full.
- uart_rx  in  1  serial input, idle high, asynchronous to pclk.
- rx_rxff_wr  out  1  one-pclk RX FIFO write strobe.
- rx_data  out  8  received byte.
- rx_parity_err  out  1  parity error flag for rx_data.
- rx_frame_err  out  1  framing error flag for rx_data.
- rx_overrun  out  1  one-pclk pulse when a byte is dropped.
- uart_rts  out  1  flow-control output; 1 = peer stop sending.
- rx_busy  out  1  1 while the receiver is not IDLE.

Function
REQ-003 uart_rx SHALL pass through a 2-flop synchronizer, reset to 1 (rx_s); all logic SHALL use rx_s only.
REQ-004 Frame format: start bit (0), 8 data bits LSB first, parity bit only when apb_d9=1, then 1 stop bit (1).
REQ-005 Parity SHALL be even: the expected parity bit is the XOR of the 8 data bits.
REQ-006 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; state and counters SHALL change only on cycles where brg_rx_sample=1, except for REQ-013.
REQ-007 IDLE: on a tick with apb_rx_en=1 and rx_s=0, the FSM SHALL go to START and clear the 4-bit tick counter (tcnt); otherwise it SHALL stay in IDLE.
REQ-008 START: on each tick, tcnt SHALL increment. On the tick where tcnt==7, rx_s SHALL be sampled:
- if rx_s=0, go to DATA, clear tcnt and the 3-bit bit index, and latch apb_d9 for the frame;
- if rx_s=1, treat it as a false start and go to IDLE with no write.
REQ-009 DATA, PARITY and STOP SHALL each sample rx_s on the tick where tcnt==15; tcnt SHALL wrap from 15 to 0 on that tick.
REQ-010 DATA: each sample SHALL shift into the shift register MSB, with a right shift. After the 8th sample, the FSM SHALL go to PARITY if the latched d9=1, else to STOP.
REQ-011 PARITY: a mismatch SHALL set a pending parity error; the FSM SHALL then go to STOP.
REQ-012 STOP: the sample SHALL be taken, a sampled 0 SHALL mean a framing error, and the FSM SHALL go to IDLE on the same tick. On the next pclk edge:
- if rx_rxff_full=0: rx_rxff_wr=1 for exactly one cycle; rx_data, rx_parity_err and rx_frame_err update and hold until the next write.
- if rx_rxff_full=1: no write; rx_data and the flags are unchanged; rx_overrun=1 for one cycle.
REQ-013 When apb_rx_en=0, on the next pclk edge the FSM SHALL go to IDLE (abort), clear tcnt, the bit index and the pending parity error, and perform no write; the synchronizer keeps running.
REQ-014 Parity error SHALL always be 0 when the latched d9=0.
REQ-015 uart_rts SHALL equal apb_af & rx_rxff_full (combinational); it SHALL be 0 when apb_af=0.
REQ-016 rx_busy SHALL be 1 in every state except IDLE.
REQ-017 A write and the next start detection SHALL not conflict: the FSM re-enters IDLE at mid-stop-bit and SHALL accept a start falling edge from the next tick onward.

Reset
REQ-018 On prst_n=0, immediately:
- FSM=IDLE, tcnt=0, bit index=0, shift register=0x00, synchronizer flops=1;
- rx_data=0x00, rx_parity_err=0, rx_frame_err=0, rx_rxff_wr=0, rx_overrun=0, rx_busy=0.
REQ-019 Reset asserted mid-frame SHALL discard the frame with no write; after release the receiver SHALL wait for a fresh start bit.

Verification
REQ-020 apb_d9=0, rx_rxff_full=0, send 0xA5 with stop=1 -> a single rx_rxff_wr pulse, rx_data=0xA5, both error flags=0.
REQ-021 apb_d9=1, send 0x3C with parity bit 0, then 0x3D with parity bit 0 -> first: rx_data=0x3C with parity_err=0; second: rx_data=0x3D with parity_err=1.
REQ-022 Send 0x55 with stop=0 -> write with rx_data=0x55 and frame_err=1; a low pulse of 5 ticks on an idle line -> no write and rx_busy back to 0.
REQ-023 rx_rxff_full=1, apb_af=1, send 0x81 -> uart_rts=1, no write, one rx_overrun pulse, rx_data unchanged; with apb_af=0 -> uart_rts=0.
REQ-024 Deassert apb_rx_en during data bit 4, then prst_n low during a later frame -> each aborted frame produces no write and the FSM returns to IDLE; the next frame 0x0F is received correctly.
